// File: rtl/pipe_shadow_tracker.sv
// Shadow model of an in-order N-stage pipeline: tracks per-stage PC/insn/valid and compares it
// against the core. Optional PC-sequence check under `define PIPE_SHADOW_SEQ_CHECK_EN.
module pipe_shadow_tracker #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     STAGES   = 6,
  parameter logic [XLEN-1:0] PC_INIT  = 'h200,
  parameter logic [XLEN-1:0] NOP_INSN = 'h13,
  parameter int unsigned     PC_ALIGN = 4,
  parameter int unsigned     CNT_W    = 32,
  localparam int unsigned    IdxW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_valid_i,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic [XLEN-1:0]          fetch_insn_i,
  input  logic [STAGES-1:0]        stall_i,
  input  logic [STAGES-1:0]        flush_i,
  input  logic                     check_en_i,
  input  logic [STAGES-1:0]        dut_valid_i,
  input  logic [STAGES*XLEN-1:0]   dut_pc_i,
  input  logic [STAGES*XLEN-1:0]   dut_insn_i,
  output logic [STAGES-1:0]        stage_valid_o,
  output logic [STAGES*XLEN-1:0]   stage_pc_o,
  output logic [STAGES*XLEN-1:0]   stage_insn_o,
  output logic [STAGES-1:0]        err_o,
  output logic [IdxW-1:0]          first_err_stage_o,
  output logic [CNT_W-1:0]         first_err_cycle_o,
  output logic                     retire_o,
  output logic [CNT_W-1:0]         retire_cnt_o,
  output logic                     seq_err_o
);

  localparam int unsigned Last = STAGES - 1;

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] valid_d, valid_q;
  logic [XLEN-1:0]   pc_d   [STAGES];
  logic [XLEN-1:0]   pc_q   [STAGES];
  logic [XLEN-1:0]   insn_d [STAGES];
  logic [XLEN-1:0]   insn_q [STAGES];
  logic [XLEN-1:0]   fetch_pc_aligned;

  logic [STAGES-1:0] mismatch;
  logic [STAGES-1:0] err_d, err_q;
  logic [IdxW-1:0]   first_idx;
  logic [IdxW-1:0]   first_stage_d, first_stage_q;
  logic [CNT_W-1:0]  first_cycle_d, first_cycle_q;
  logic [CNT_W-1:0]  cycle_d, cycle_q;
  logic [CNT_W-1:0]  retire_cnt_d, retire_cnt_q;
  logic              retire_d, retire_q;
  logic              retire_cond;

  // A stall anywhere downstream freezes every stage upstream of it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc     = acc | stall_i[k];
      hold[k] = acc;
    end
  end

  assign fetch_pc_aligned = fetch_pc_i & ~XLEN'(PC_ALIGN - 1);

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < int'(STAGES); k++) begin
      pc_d[k]   = pc_q[k];
      insn_d[k] = insn_q[k];
    end

    if (flush_i[0]) begin
      valid_d[0] = 1'b0;
    end else if (!hold[0]) begin
      valid_d[0] = fetch_valid_i;
      pc_d[0]    = fetch_pc_aligned;
      insn_d[0]  = fetch_insn_i;
    end

    for (int k = 1; k < int'(STAGES); k++) begin
      if (flush_i[k]) begin
        valid_d[k] = 1'b0;
      end else if (!hold[k]) begin
        // A held upstream stage leaves a bubble behind the stall.
        valid_d[k] = valid_q[k-1] & ~hold[k-1];
        pc_d[k]    = pc_q[k-1];
        insn_d[k]  = insn_q[k-1];
      end
    end
  end

  always_comb begin
    mismatch = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      mismatch[k] = check_en_i &
                    ((dut_valid_i[k] != valid_q[k]) |
                     (dut_valid_i[k] & valid_q[k] &
                      ((dut_pc_i[k*XLEN +: XLEN] != pc_q[k]) |
                       (dut_insn_i[k*XLEN +: XLEN] != insn_q[k]))));
    end
  end

  always_comb begin
    first_idx = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (mismatch[k]) first_idx = IdxW'(k);
    end
  end

  always_comb begin
    err_d         = err_q | mismatch;
    first_stage_d = first_stage_q;
    first_cycle_d = first_cycle_q;
    if ((err_q == '0) && (|mismatch)) begin
      first_stage_d = first_idx;
      first_cycle_d = cycle_q;
    end
  end

  assign retire_cond  = valid_q[Last] & ~flush_i[Last] & ~stall_i[Last];
  assign retire_d     = retire_cond;
  assign retire_cnt_d = retire_cnt_q + CNT_W'(retire_cond);
  assign cycle_d      = cycle_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        pc_q[k]   <= PC_INIT;
        insn_q[k] <= NOP_INSN;
      end
      err_q         <= '0;
      first_stage_q <= '0;
      first_cycle_q <= '0;
      cycle_q       <= '0;
      retire_q      <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        pc_q[k]   <= pc_d[k];
        insn_q[k] <= insn_d[k];
      end
      err_q         <= err_d;
      first_stage_q <= first_stage_d;
      first_cycle_q <= first_cycle_d;
      cycle_q       <= cycle_d;
      retire_q      <= retire_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

`ifdef PIPE_SHADOW_SEQ_CHECK_EN
  logic [XLEN-1:0] last_pc_d, last_pc_q;
  logic [XLEN-1:0] last_insn_d, last_insn_q;
  logic            redirect_d, redirect_q;
  logic            seen_d, seen_q;
  logic            seq_err_d, seq_err_q;
  logic            last_is_jump;

  // Branches, JALR and JAL may legitimately break PC+4 sequencing.
  assign last_is_jump = (last_insn_q[6:2] == 5'b11000) || (last_insn_q[6:2] == 5'b11001) ||
                        (last_insn_q[6:2] == 5'b11011);

  always_comb begin
    last_pc_d   = last_pc_q;
    last_insn_d = last_insn_q;
    redirect_d  = redirect_q;
    seen_d      = seen_q;
    seq_err_d   = seq_err_q;
    if (retire_cond) begin
      if (seen_q && !redirect_q && !last_is_jump && (pc_q[Last] != last_pc_q + XLEN'(4))) begin
        seq_err_d = 1'b1;
      end
      last_pc_d   = pc_q[Last];
      last_insn_d = insn_q[Last];
      seen_d      = 1'b1;
      redirect_d  = 1'b0;
    end
    if (|flush_i) redirect_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc_q   <= '0;
      last_insn_q <= '0;
      redirect_q  <= 1'b0;
      seen_q      <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      last_pc_q   <= last_pc_d;
      last_insn_q <= last_insn_d;
      redirect_q  <= redirect_d;
      seen_q      <= seen_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seq_err_o = seq_err_q;
`else
  assign seq_err_o = 1'b0;
`endif

  always_comb begin
    stage_pc_o   = '0;
    stage_insn_o = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      stage_pc_o[k*XLEN +: XLEN]   = pc_q[k];
      stage_insn_o[k*XLEN +: XLEN] = insn_q[k];
    end
  end

  assign stage_valid_o     = valid_q;
  assign err_o             = err_q;
  assign first_err_stage_o = first_stage_q;
  assign first_err_cycle_o = first_cycle_q;
  assign retire_o          = retire_q;
  assign retire_cnt_o      = retire_cnt_q;

endmodule

// File: tb/tb_pipe_shadow_tracker.sv
// Directed self-checking bench for pipe_shadow_tracker (6 stages, 32-bit).
module tb_pipe_shadow_tracker;

  localparam int S = 6;
  localparam int X = 32;

  logic           clk;
  logic           rst_n;
  logic           fetch_valid_i;
  logic [X-1:0]   fetch_pc_i;
  logic [X-1:0]   fetch_insn_i;
  logic [S-1:0]   stall_i;
  logic [S-1:0]   flush_i;
  logic           check_en_i;
  logic [S-1:0]   dut_valid_i;
  logic [S*X-1:0] dut_pc_i;
  logic [S*X-1:0] dut_insn_i;
  logic [S-1:0]   stage_valid_o;
  logic [S*X-1:0] stage_pc_o;
  logic [S*X-1:0] stage_insn_o;
  logic [S-1:0]   err_o;
  logic [2:0]     first_err_stage_o;
  logic [31:0]    first_err_cycle_o;
  logic           retire_o;
  logic [31:0]    retire_cnt_o;
  logic           seq_err_o;

  int errors;
  int checks;
  int cyc;

  pipe_shadow_tracker dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_valid_i     (fetch_valid_i),
    .fetch_pc_i        (fetch_pc_i),
    .fetch_insn_i      (fetch_insn_i),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .check_en_i        (check_en_i),
    .dut_valid_i       (dut_valid_i),
    .dut_pc_i          (dut_pc_i),
    .dut_insn_i        (dut_insn_i),
    .stage_valid_o     (stage_valid_o),
    .stage_pc_o        (stage_pc_o),
    .stage_insn_o      (stage_insn_o),
    .err_o             (err_o),
    .first_err_stage_o (first_err_stage_o),
    .first_err_cycle_o (first_err_cycle_o),
    .retire_o          (retire_o),
    .retire_cnt_o      (retire_cnt_o),
    .seq_err_o         (seq_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pc_of(int i);
    return 32'h200 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] insn_of(int i);
    return 32'h33 | (32'(i) << 7);
  endfunction

  function automatic logic [31:0] spc(int k);
    return stage_pc_o[k*X +: X];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic feed_raw(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                          input logic [S-1:0] st, input logic [S-1:0] fl);
    fetch_valid_i = v;
    fetch_pc_i    = pc;
    fetch_insn_i  = insn;
    stall_i       = st;
    flush_i       = fl;
    step();
  endtask

  task automatic feed_cycle(input logic v, input int i, input logic [S-1:0] st,
                            input logic [S-1:0] fl);
    feed_raw(v, pc_of(i), insn_of(i), st, fl);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pc_i    = '0;
    fetch_insn_i  = '0;
    stall_i       = '0;
    flush_i       = '0;
    check_en_i    = 1'b0;
    dut_valid_i   = '0;
    dut_pc_i      = '0;
    dut_insn_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Stage k ends up holding instruction 5-k, frozen by a stall at the last stage.
  task automatic fill_and_freeze();
    for (int t = 1; t <= 6; t++) feed_cycle(1'b1, t - 1, '0, '0);
    fetch_valid_i = 1'b0;
    stall_i       = 6'b100000;
  endtask

  task automatic set_dut_match();
    for (int k = 0; k < S; k++) begin
      dut_valid_i[k]        = 1'b1;
      dut_pc_i[k*X +: X]    = pc_of(5 - k);
      dut_insn_i[k*X +: X]  = insn_of(5 - k);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int t = 1; t <= 8; t++) feed_cycle(1'b1, t - 1, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage_valid_o !== 6'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected %b", stage_valid_o, 6'b0);
    end
    checks++;
    if (stage_pc_o !== {S{32'h200}}) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", stage_pc_o, {S{32'h200}});
    end
    checks++;
    if (stage_insn_o !== {S{32'h13}}) begin
      errors++; $display("FAIL reset_insn: got %h expected %h", stage_insn_o, {S{32'h13}});
    end
    checks++;
    if ({err_o, first_err_stage_o, first_err_cycle_o, retire_o, seq_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_err: got err=%b stage=%0d cycle=%0d ret=%b seq=%b expected all 0",
               err_o, first_err_stage_o, first_err_cycle_o, retire_o, seq_err_o);
    end
    checks++;
    if (retire_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_retire_cnt: got %0d expected 0", retire_cnt_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_basic();
    logic exp_ret;
    do_reset();
    for (int t = 1; t <= 14; t++) begin
      feed_cycle(t <= 6, t - 1, '0, '0);
      if (t == 6) begin
        checks++;
        if (spc(5) !== 32'h200 || stage_valid_o[5] !== 1'b1) begin
          errors++;
          $display("FAIL basic_latency: got pc=%h v=%b expected pc=200 v=1",
                   spc(5), stage_valid_o[5]);
        end
      end
      exp_ret = (t >= 7) && (t <= 12);
      checks++;
      if (retire_o !== exp_ret) begin
        errors++; $display("FAIL basic_retire_t%0d: got %b expected %b", t, retire_o, exp_ret);
      end
    end
    checks++;
    if (retire_cnt_o !== 32'd6) begin
      errors++; $display("FAIL basic_retire_cnt: got %0d expected 6", retire_cnt_o);
    end
    checks++;
    if (err_o !== 6'b0) begin
      errors++; $display("FAIL basic_err: got %b expected 000000", err_o);
    end
  endtask

  task automatic test_stall();
    int p;
    logic [S-1:0] st;
    do_reset();
    p = 0;
    for (int t = 1; t <= 20; t++) begin
      st = (t == 6 || t == 7) ? 6'b000100 : 6'b0;
      feed_cycle(p < 8, p, st, '0);
      if (st == 6'b0 && p < 8) p++;
      if (t == 6 || t == 7) begin
        checks++;
        if (stage_valid_o[3] !== 1'b0 || spc(2) !== 32'h208 || spc(0) !== 32'h210 ||
            stage_valid_o[2:0] !== 3'b111) begin
          errors++;
          $display("FAIL stall_freeze_t%0d: got v=%b pc0=%h pc2=%h expected v[3:0]=0111 pc0=210 pc2=208",
                   t, stage_valid_o, spc(0), spc(2));
        end
      end
      if (t == 8) begin
        checks++;
        if (stage_valid_o[3] !== 1'b1 || spc(3) !== 32'h208 || spc(0) !== 32'h214) begin
          errors++;
          $display("FAIL stall_resume: got v3=%b pc3=%h pc0=%h expected 1 208 214",
                   stage_valid_o[3], spc(3), spc(0));
        end
      end
    end
    checks++;
    if (retire_cnt_o !== 32'd8) begin
      errors++; $display("FAIL stall_retire_cnt: got %0d expected 8", retire_cnt_o);
    end
  endtask

  task automatic test_flush();
    logic [S-1:0] fl;
    do_reset();
    for (int t = 1; t <= 16; t++) begin
      fl = (t == 5) ? 6'b000011 : 6'b0;
      feed_cycle(t <= 8, t - 1, '0, fl);
      if (t == 5) begin
        checks++;
        if (stage_valid_o[2:0] !== 3'b100 || spc(2) !== 32'h208) begin
          errors++;
          $display("FAIL flush_bubble: got v=%b pc2=%h expected v[2:0]=100 pc2=208",
                   stage_valid_o, spc(2));
        end
      end
      checks++;
      if (stage_valid_o[5] && (spc(5) == 32'h20C || spc(5) == 32'h210)) begin
        errors++; $display("FAIL flush_leak_t%0d: got pc5=%h at WB expected flushed", t, spc(5));
      end
    end
    checks++;
    if (retire_cnt_o !== 32'd6) begin
      errors++; $display("FAIL flush_retire_cnt: got %0d expected 6", retire_cnt_o);
    end
  endtask

  task automatic test_mismatch();
    int exp_cyc;
    do_reset();
    fill_and_freeze();
    set_dut_match();
    check_en_i = 1'b1;
    step();
    checks++;
    if (err_o !== 6'b0) begin
      errors++; $display("FAIL mm_clean: got %b expected 000000", err_o);
    end
    check_en_i = 1'b0;
    dut_pc_i[3*X +: X] = pc_of(2) + 32'd4;
    step();
    checks++;
    if (err_o !== 6'b0) begin
      errors++; $display("FAIL mm_disabled: got %b expected 000000", err_o);
    end
    check_en_i = 1'b1;
    exp_cyc = cyc;
    step();
    set_dut_match();
    checks++;
    if (err_o !== 6'b001000) begin
      errors++; $display("FAIL mm_err: got %b expected 001000", err_o);
    end
    checks++;
    if (first_err_stage_o !== 3'd3 || first_err_cycle_o !== 32'(exp_cyc)) begin
      errors++;
      $display("FAIL mm_first: got stage=%0d cycle=%0d expected stage=3 cycle=%0d",
               first_err_stage_o, first_err_cycle_o, exp_cyc);
    end
    step();
    step();
    checks++;
    if (err_o !== 6'b001000) begin
      errors++; $display("FAIL mm_sticky: got %b expected 001000", err_o);
    end
  endtask

  task automatic test_simultaneous();
    int exp_cyc;
    do_reset();
    fill_and_freeze();
    set_dut_match();
    check_en_i = 1'b1;
    dut_insn_i[1*X +: X] = insn_of(4) ^ 32'h100;
    dut_valid_i[4]       = 1'b0;
    exp_cyc = cyc;
    step();
    set_dut_match();
    checks++;
    if (err_o !== 6'b010010) begin
      errors++; $display("FAIL sim_err: got %b expected 010010", err_o);
    end
    checks++;
    if (first_err_stage_o !== 3'd1 || first_err_cycle_o !== 32'(exp_cyc)) begin
      errors++;
      $display("FAIL sim_first: got stage=%0d cycle=%0d expected stage=1 cycle=%0d",
               first_err_stage_o, first_err_cycle_o, exp_cyc);
    end
    dut_valid_i[0] = 1'b0;
    step();
    set_dut_match();
    checks++;
    if (err_o !== 6'b010011 || first_err_stage_o !== 3'd1 ||
        first_err_cycle_o !== 32'(exp_cyc)) begin
      errors++;
      $display("FAIL sim_later: got err=%b stage=%0d cycle=%0d expected 010011 1 %0d",
               err_o, first_err_stage_o, first_err_cycle_o, exp_cyc);
    end
  endtask

  task automatic test_seq();
    logic exp_jump_gap;
    do_reset();
    feed_raw(1'b1, 32'h200, 32'h0000_0033, '0, '0);
    feed_raw(1'b1, 32'h208, 32'h0000_00B3, '0, '0);
    for (int t = 0; t < 8; t++) feed_raw(1'b0, '0, '0, '0, '0);
`ifdef PIPE_SHADOW_SEQ_CHECK_EN
    exp_jump_gap = 1'b1;
`else
    exp_jump_gap = 1'b0;
`endif
    checks++;
    if (seq_err_o !== exp_jump_gap || retire_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL seq_add_gap: got seq=%b cnt=%0d expected seq=%b cnt=2",
               seq_err_o, retire_cnt_o, exp_jump_gap);
    end
    do_reset();
    feed_raw(1'b1, 32'h200, 32'h0000_006F, '0, '0);
    feed_raw(1'b1, 32'h300, 32'h0000_0033, '0, '0);
    for (int t = 0; t < 8; t++) feed_raw(1'b0, '0, '0, '0, '0);
    checks++;
    if (seq_err_o !== 1'b0 || retire_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL seq_jal: got seq=%b cnt=%0d expected seq=0 cnt=2", seq_err_o, retire_cnt_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    do_reset();
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_mismatch();
    test_simultaneous();
    test_seq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
